bellek_hakemi: RTL and testbench
================================

Name: bellek_hakemi

Overview:
Round-robin arbiter that shares the single external iomem bus between two requesters.
- Requester B: L1 instruction-cache miss path, read-only.
- Requester V: L1 data-cache / uncached data path, read and write.
It sits between the cache controllers and the memory interface. It grants one requester at a time, holds the grant until the memory answers, and aborts hung transactions with a watchdog.

Parameters:
ZAMAN_ASIMI, 255, watchdog limit in cycles spent in a grant state without iomem_ready; 0 disables the watchdog; range 0..255, 8-bit counter.

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  asynchronous, active-high reset
b_valid_i  input  1  B request; held with b_addr_i stable until b_ready_o
b_addr_i  input  17  B word address [18:2]
b_ready_o  output  1  B transfer complete this cycle
b_rdata_o  output  32  B read data, valid when b_ready_o=1
v_valid_i  input  1  V request; held with addr/wdata/wstrb stable until v_ready_o
v_addr_i  input  17  V word address [18:2]
v_wstrb_i  input  4  V byte write strobes; 0 = read
v_wdata_i  input  32  V write data
v_ready_o  output  1  V transfer complete this cycle
v_rdata_o  output  32  V read data, valid when v_ready_o=1
iomem_valid  output  1  memory request
iomem_ready  input  1  memory completion
iomem_addr  output  17  memory word address [18:2]
iomem_wstrb  output  4  memory byte strobes; always 0 during a B grant
iomem_wdata  output  32  memory write data; 0 during a B grant
iomem_rdata  input  32  memory read data
hata_o  output  1  sticky watchdog-abort flag

Behaviour:
State machine states: BOS (idle), IZIN_B, IZIN_V.
- State is registered; iomem_valid is decoded from state.

Reset (asynchronous, immediate on rst_i):
- state=BOS, son_izin=V (so B wins the first tie), sayac=0, hata_o=0.
- All outputs 0 while in BOS.

BOS transitions:
- b_valid_i && v_valid_i -> the requester not equal to son_izin.
- Only one valid -> that requester.
- None -> stay in BOS.
- Grant takes effect next cycle; minimum latency from request to iomem_valid is 1 cycle.

Grant state X (X = B or V):
- iomem_valid = X_valid_i.
- iomem_addr / iomem_wstrb / iomem_wdata are combinationally muxed from X.
- In BOS, iomem_addr/wstrb/wdata = 0.

Completion:
- iomem_ready=1 while in IZIN_X -> X_ready_o=1 in the same cycle, X_rdata_o = iomem_rdata.
- Next state BOS; son_izin <= X; sayac <= 0.
- One bubble cycle always separates consecutive transactions.

Non-granted requester:
- ready_o=0 and rdata_o=0.
- rdata_o is also 0 whenever ready_o=0.

Watchdog (ZAMAN_ASIMI != 0):
- sayac increments each grant cycle without iomem_ready.
- When sayac == ZAMAN_ASIMI-1 and iomem_ready=0: X_ready_o=1 with X_rdata_o=0; hata_o <= 1 (cleared only by reset); next state BOS; son_izin <= X.
- iomem_ready and timeout in the same cycle -> ready wins; normal completion, no error.

Requester drops valid while granted (protocol violation):
- iomem_valid falls the same cycle; state returns to BOS next cycle; no ready is issued; son_izin is unchanged.

Requests arriving during a grant wait; they are arbitrated in the next BOS cycle.

Timing: no combinational path from iomem_ready to iomem_valid.

Test Plan:
- Single B read: b_valid_i=1, addr=17'h00010. iomem_valid rises 1 cycle later with iomem_addr=17'h00010, wstrb=0. Memory returns ready after 3 cycles with rdata=32'h00000013 -> b_ready_o pulses 1 cycle with b_rdata_o=32'h00000013; v_ready_o stays 0.
- Single V write: v_addr=17'h1FFFF, wstrb=4'b0011, wdata=32'hCAFEBABE -> iomem outputs carry exactly these values; v_ready_o on iomem_ready; the next request waits for one BOS cycle.
- Simultaneous requests after reset, both held, memory ready every grant -> grant order B, V, B, V; each transaction separated by one BOS cycle.
- Watchdog with ZAMAN_ASIMI=4: V grant, iomem_ready held 0 -> v_ready_o=1 with v_rdata_o=0 on the 4th grant cycle, hata_o=1 and stays 1. A later B read completes normally; hata_o remains 1 until rst_i.
- Ready and timeout in the same cycle (ready on the 4th cycle, ZAMAN_ASIMI=4) -> normal completion with rdata passed through; hata_o stays 0.
- rst_i asserted mid-grant, between clock edges -> iomem_valid, ready_o and hata_o drop to 0 immediately. After release with both requests active, B is granted first.

Source files
------------

// File: rtl/bellek_hakemi.sv
// Round-robin arbiter sharing the iomem bus between the instruction-miss path (B)
// and the data path (V), with a per-grant watchdog and a sticky abort flag.
//
// state  | meaning
// BOS    | idle; arbitrate pending requests (loser of the last grant wins ties)
// IZIN_B | B owns iomem until iomem_ready, watchdog expiry or B dropping valid
// IZIN_V | V owns iomem until iomem_ready, watchdog expiry or V dropping valid
module bellek_hakemi #(
  parameter int unsigned ZAMAN_ASIMI = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        b_valid_i,
  input  logic [16:0] b_addr_i,
  output logic        b_ready_o,
  output logic [31:0] b_rdata_o,
  input  logic        v_valid_i,
  input  logic [16:0] v_addr_i,
  input  logic [3:0]  v_wstrb_i,
  input  logic [31:0] v_wdata_i,
  output logic        v_ready_o,
  output logic [31:0] v_rdata_o,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [16:0] iomem_addr,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata,
  output logic        hata_o
);

  typedef enum logic [1:0] {BOS, IZIN_B, IZIN_V} durum_t;

  localparam bit         WD_ACIK = (ZAMAN_ASIMI != 0);
  localparam logic [7:0] SINIR   = WD_ACIK ? 8'(ZAMAN_ASIMI - 1) : 8'd0;

  durum_t     durum;
  logic       son_izin_v;
  logic [7:0] sayac;
  logic       hata;

  logic izin_b, izin_v, aktif, zaman_doldu, bitti;

  assign izin_b      = (durum == IZIN_B);
  assign izin_v      = (durum == IZIN_V);
  assign aktif       = (izin_b & b_valid_i) | (izin_v & v_valid_i);
  assign zaman_doldu = WD_ACIK && aktif && !iomem_ready && (sayac == SINIR);
  assign bitti       = aktif & (iomem_ready | zaman_doldu);

  assign iomem_valid = aktif;
  assign hata_o      = hata;

  always_comb begin
    iomem_addr  = '0;
    iomem_wstrb = '0;
    iomem_wdata = '0;
    if (izin_b) begin
      iomem_addr = b_addr_i;
    end else if (izin_v) begin
      iomem_addr  = v_addr_i;
      iomem_wstrb = v_wstrb_i;
      iomem_wdata = v_wdata_i;
    end
  end

  // On a watchdog abort iomem_ready is low, so the read data is forced to zero.
  assign b_ready_o = izin_b & bitti;
  assign v_ready_o = izin_v & bitti;
  assign b_rdata_o = (b_ready_o && iomem_ready) ? iomem_rdata : '0;
  assign v_rdata_o = (v_ready_o && iomem_ready) ? iomem_rdata : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum      <= BOS;
      son_izin_v <= 1'b1;
      sayac      <= '0;
      hata       <= 1'b0;
    end else begin
      case (durum)
        BOS: begin
          sayac <= '0;
          if (b_valid_i && (!v_valid_i || son_izin_v))
            durum <= IZIN_B;
          else if (v_valid_i)
            durum <= IZIN_V;
        end
        IZIN_B, IZIN_V: begin
          if (!aktif) begin
            durum <= BOS;
            sayac <= '0;
          end else if (bitti) begin
            durum      <= BOS;
            son_izin_v <= izin_v;
            sayac      <= '0;
            if (zaman_doldu)
              hata <= 1'b1;
          end else begin
            sayac <= sayac + 8'd1;
          end
        end
        default: durum <= BOS;
      endcase
    end
  end

endmodule

// File: tb/tb_bellek_hakemi.sv
// Scoreboard bench for bellek_hakemi: requester/memory models drive the DUT, a
// monitor pops expected transactions whenever a ready pulse appears.
module tb_bellek_hakemi;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        b_valid_i = 1'b0;
  logic [16:0] b_addr_i = '0;
  logic        b_ready_o;
  logic [31:0] b_rdata_o;
  logic        v_valid_i = 1'b0;
  logic [16:0] v_addr_i = '0;
  logic [3:0]  v_wstrb_i = '0;
  logic [31:0] v_wdata_i = '0;
  logic        v_ready_o;
  logic [31:0] v_rdata_o;
  logic        iomem_valid;
  logic        iomem_ready = 1'b0;
  logic [16:0] iomem_addr;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata = 32'hDEAD_BEEF;
  logic        hata_o;

  bellek_hakemi #(.ZAMAN_ASIMI(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .b_valid_i(b_valid_i), .b_addr_i(b_addr_i), .b_ready_o(b_ready_o), .b_rdata_o(b_rdata_o),
    .v_valid_i(v_valid_i), .v_addr_i(v_addr_i), .v_wstrb_i(v_wstrb_i), .v_wdata_i(v_wdata_i),
    .v_ready_o(v_ready_o), .v_rdata_o(v_rdata_o),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_addr(iomem_addr),
    .iomem_wstrb(iomem_wstrb), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .hata_o(hata_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          v;
    logic [16:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [16:0] a;
    logic [3:0]  s;
    logic [31:0] d;
  } vreq_t;

  exp_t          exp_q[$];
  logic [16:0]   bq[$];
  vreq_t         vq[$];
  bit            b_fire = 0, v_fire = 0;
  int            lat = 1;
  int            n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] mrd(input logic [16:0] a);
    return {15'h0, a} + 32'd3;
  endfunction

  task automatic rq_b(input logic [16:0] a);
    bq.push_back(a);
  endtask

  task automatic rq_v(input logic [16:0] a, input logic [3:0] s, input logic [31:0] d);
    vreq_t r;
    r.a = a; r.s = s; r.d = d;
    vq.push_back(r);
  endtask

  task automatic ex(input bit v, input logic [16:0] a, input logic [3:0] s,
                    input logic [31:0] d, input logic [31:0] rd, input int cyc);
    exp_t e;
    e.v = v; e.addr = a; e.wstrb = s; e.wdata = d; e.rdata = rd; e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  // Requesters present the queue head; memory answers on grant cycle `lat` (0 = never).
  initial begin
    int k;
    k = 0;
    forever begin
      @(posedge clk_i);
      #1;
      if (b_fire) begin if (bq.size() > 0) void'(bq.pop_front()); b_fire = 0; end
      if (v_fire) begin if (vq.size() > 0) void'(vq.pop_front()); v_fire = 0; end
      b_valid_i = (bq.size() > 0);
      if (bq.size() > 0) b_addr_i = bq[0];
      v_valid_i = (vq.size() > 0);
      if (vq.size() > 0) begin
        v_addr_i = vq[0].a; v_wstrb_i = vq[0].s; v_wdata_i = vq[0].d;
      end
      #1;
      k = (iomem_valid && !rst_i) ? k + 1 : 0;
      iomem_ready = (lat != 0) && (k == lat);
      iomem_rdata = iomem_ready ? mrd(iomem_addr) : 32'hDEAD_BEEF;
    end
  end

  // Monitor
  initial begin
    int   gcnt;
    bit   prev_done;
    exp_t e;
    gcnt = 0; prev_done = 0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        gcnt = 0; prev_done = 0;
      end else begin
        gcnt = iomem_valid ? gcnt + 1 : 0;
        if (prev_done) chk("bubble", {31'b0, iomem_valid}, 32'd0);
        prev_done = b_ready_o | v_ready_o;
        if (b_ready_o || v_ready_o) begin
          b_fire = b_ready_o;
          v_fire = v_ready_o;
          if (exp_q.size() == 0) begin
            chk("unexpected_ready", {30'b0, b_ready_o, v_ready_o}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("ready_b", {31'b0, b_ready_o}, {31'b0, !e.v});
            chk("ready_v", {31'b0, v_ready_o}, {31'b0, e.v});
            chk("addr", {15'b0, iomem_addr}, {15'b0, e.addr});
            chk("wstrb", {28'b0, iomem_wstrb}, {28'b0, e.wstrb});
            chk("wdata", iomem_wdata, e.wdata);
            chk("rdata", e.v ? v_rdata_o : b_rdata_o, e.rdata);
            chk("idle_rdata", e.v ? b_rdata_o : v_rdata_o, 32'd0);
            chk("grant_cycles", gcnt, e.cyc);
          end
        end
      end
    end
  end

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bq.size() != 0 || vq.size() != 0) && n < bound) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= bound) begin
      chk("drain_timeout", exp_q.size(), 32'd0);
      exp_q.delete(); bq.delete(); vq.delete();
    end
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    repeat (2) @(negedge clk_i);
    chk("rst_iomem_valid", {31'b0, iomem_valid}, 32'd0);
    chk("rst_ready", {30'b0, b_ready_o, v_ready_o}, 32'd0);
    chk("rst_hata", {31'b0, hata_o}, 32'd0);
    chk("rst_addr", {15'b0, iomem_addr}, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Single B read, latency check
    lat = 3;
    rq_b(17'h00010);
    ex(0, 17'h00010, 4'h0, 32'h0, 32'h0000_0013, 3);
    @(negedge clk_i);
    chk("lat_bos", {31'b0, iomem_valid}, 32'd0);
    @(negedge clk_i);
    chk("lat_grant", {31'b0, iomem_valid}, 32'd1);
    chk("lat_addr", {15'b0, iomem_addr}, 32'h10);
    drain(20);

    // V write then V read
    lat = 2;
    rq_v(17'h1FFFF, 4'b0011, 32'hCAFE_BABE);
    ex(1, 17'h1FFFF, 4'b0011, 32'hCAFE_BABE, 32'h0002_0002, 2);
    drain(20);
    lat = 1;
    rq_v(17'h00123, 4'h0, 32'h0);
    ex(1, 17'h00123, 4'h0, 32'h0, 32'h0000_0126, 1);
    drain(20);

    // Both requesters held: alternation B, V, B, V
    rq_b(17'h00100); rq_b(17'h00101);
    rq_v(17'h00200, 4'h0, 32'h0); rq_v(17'h00201, 4'hF, 32'h1111_2222);
    ex(0, 17'h00100, 4'h0, 32'h0, 32'h0000_0103, 1);
    ex(1, 17'h00200, 4'h0, 32'h0, 32'h0000_0203, 1);
    ex(0, 17'h00101, 4'h0, 32'h0, 32'h0000_0104, 1);
    ex(1, 17'h00201, 4'hF, 32'h1111_2222, 32'h0000_0204, 1);
    drain(40);

    // Watchdog abort on the 4th grant cycle
    chk("hata_before", {31'b0, hata_o}, 32'd0);
    lat = 0;
    rq_v(17'h00055, 4'hF, 32'h0000_1234);
    ex(1, 17'h00055, 4'hF, 32'h0000_1234, 32'h0, 4);
    drain(20);
    chk("hata_set", {31'b0, hata_o}, 32'd1);

    // Later B read completes normally; flag is sticky
    lat = 2;
    rq_b(17'h00020);
    ex(0, 17'h00020, 4'h0, 32'h0, 32'h0000_0023, 2);
    drain(20);
    chk("hata_sticky", {31'b0, hata_o}, 32'd1);

    // Async reset mid-grant, then tie goes to B
    lat = 0;
    rq_b(17'h00077);
    repeat (3) @(negedge clk_i);
    chk("pre_rst_grant", {31'b0, iomem_valid}, 32'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_iomem_valid", {31'b0, iomem_valid}, 32'd0);
    chk("arst_ready", {30'b0, b_ready_o, v_ready_o}, 32'd0);
    chk("arst_hata", {31'b0, hata_o}, 32'd0);
    exp_q.delete(); bq.delete(); vq.delete();
    b_fire = 0; v_fire = 0;
    lat = 1;
    rq_b(17'h00030);
    rq_v(17'h00040, 4'h0, 32'h0);
    ex(0, 17'h00030, 4'h0, 32'h0, 32'h0000_0033, 1);
    ex(1, 17'h00040, 4'h0, 32'h0, 32'h0000_0043, 1);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    drain(30);
    chk("hata_after_rst", {31'b0, hata_o}, 32'd0);

    // Ready and timeout in the same cycle: ready wins
    lat = 4;
    rq_v(17'h00099, 4'h0, 32'h0);
    ex(1, 17'h00099, 4'h0, 32'h0, 32'h0000_009C, 4);
    drain(20);
    chk("hata_ready_wins", {31'b0, hata_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
